// File: rtl/conv1_pool_if.sv
// Pixel stream into, and pooled stream out of, the conv1 max-pooling stage.
// master = upstream driver/consumer side, slave = pooling stage.
interface conv1_pool_if #(
    parameter int unsigned CONV_BIT = 12
);
    logic                       valid_in;
    logic signed [CONV_BIT-1:0] conv_in_1;
    logic signed [CONV_BIT-1:0] conv_in_2;
    logic signed [CONV_BIT-1:0] conv_in_3;
    logic signed [CONV_BIT-1:0] max_value_1;
    logic signed [CONV_BIT-1:0] max_value_2;
    logic signed [CONV_BIT-1:0] max_value_3;
    logic                       valid_out_pool;

    modport master (
        output valid_in,
        output conv_in_1,
        output conv_in_2,
        output conv_in_3,
        input  max_value_1,
        input  max_value_2,
        input  max_value_3,
        input  valid_out_pool
    );

    modport slave (
        input  valid_in,
        input  conv_in_1,
        input  conv_in_2,
        input  conv_in_3,
        output max_value_1,
        output max_value_2,
        output max_value_3,
        output valid_out_pool
    );
endinterface

// File: rtl/conv1_pool.sv
// 2x2/stride-2 signed max-pooling of a 3-channel raster conv stream.
// Optional ReLU after the max is enabled by defining CONV1_POOL_RELU_EN.
module conv1_pool #(
    parameter int unsigned CONV_BIT    = 12,
    parameter int unsigned HALF_WIDTH  = 12,
    parameter int unsigned HALF_HEIGHT = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    conv1_pool_if.slave  bus
);

    localparam int unsigned ROW_LEN = 2 * HALF_WIDTH;
    localparam int unsigned ROWS    = 2 * HALF_HEIGHT;
    localparam int unsigned COL_W   = $clog2(ROW_LEN);
    localparam int unsigned ROW_W   = $clog2(ROWS);

    typedef logic signed [CONV_BIT-1:0] sample_t;
    typedef enum logic {StEven, StOdd} phase_e;

    phase_e           r_phase;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    sample_t          r_hold [3];
    sample_t          r_buf  [3][HALF_WIDTH];
    sample_t          r_max  [3];
    logic             r_valid;

    sample_t          w_in   [3];
    sample_t          w_pair [3];
    sample_t          w_quad [3];
    sample_t          w_out  [3];
    logic [COL_W-2:0] w_slot;
    logic             w_col_last;
    logic             w_row_last;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic sample_t post_max(input sample_t m);
`ifdef CONV1_POOL_RELU_EN
        return (m < 0) ? '0 : m;
`else
        return m;
`endif
    endfunction

    always_comb begin
        w_in[0]    = bus.conv_in_1;
        w_in[1]    = bus.conv_in_2;
        w_in[2]    = bus.conv_in_3;
        w_slot     = r_col[COL_W-1:1];
        w_col_last = (r_col == COL_W'(ROW_LEN - 1));
        w_row_last = (r_row == ROW_W'(ROWS - 1));
        for (int ch = 0; ch < 3; ch++) begin
            w_pair[ch] = smax(r_hold[ch], w_in[ch]);
            w_quad[ch] = smax(r_buf[ch][w_slot], w_pair[ch]);
            w_out[ch]  = post_max(w_quad[ch]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= StEven;
            r_col   <= '0;
            r_row   <= '0;
            r_valid <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                r_hold[ch] <= '0;
                r_max[ch]  <= '0;
                for (int k = 0; k < HALF_WIDTH; k++) begin
                    r_buf[ch][k] <= '0;
                end
            end
        end else begin
            // Strobe only on the beat that completes a 2x2 block (odd row, odd col).
            r_valid <= bus.valid_in && (r_phase == StOdd) && r_col[0];
            if (bus.valid_in) begin
                if (w_col_last) begin
                    r_col <= '0;
                    if (w_row_last) begin
                        r_row   <= '0;
                        r_phase <= StEven;
                    end else begin
                        r_row   <= r_row + ROW_W'(1);
                        r_phase <= (r_phase == StEven) ? StOdd : StEven;
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end

                for (int ch = 0; ch < 3; ch++) begin
                    if (!r_col[0]) begin
                        r_hold[ch] <= w_in[ch];
                    end else if (r_phase == StEven) begin
                        r_buf[ch][w_slot] <= w_pair[ch];
                    end else begin
                        r_max[ch] <= w_out[ch];
                    end
                end
            end
        end
    end

    assign bus.max_value_1    = r_max[0];
    assign bus.max_value_2    = r_max[1];
    assign bus.max_value_3    = r_max[2];
    assign bus.valid_out_pool = r_valid;

endmodule

// File: tb/tb_conv1_pool.sv
// Scoreboard bench for conv1_pool: driver pushes hand-derived pooled values, monitor pops on strobes.
module tb_conv1_pool;

    localparam int unsigned CB = 12;
    localparam int unsigned HW = 12;
    localparam int unsigned HH = 12;
`ifdef CONV1_POOL_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    typedef struct {
        int v1;
        int v2;
        int v3;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv1_pool_if #(.CONV_BIT(CB)) bus ();

    conv1_pool #(
        .CONV_BIT   (CB),
        .HALF_WIDTH (HW),
        .HALF_HEIGHT(HH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t sb[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_strobe = 0;
    int   cyc      = 0;
    int   pos_l[4] = '{-2048, 2047, 100, -1};
    int   neg_l[4] = '{-2048, -1, -100, -2000};

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Input sample for a given test mode / channel / pixel.
    function automatic int pix(input int mode, input int ch, input int r, input int c);
        int q;
        q = (r % 2) * 2 + (c % 2);
        case (mode)
            1: return r + c;
            2: return (ch == 1) ? 7 : -5;
            3: begin
                if (r < 2 && c < 2) return pos_l[(q + ch) % 4];
                if (r < 2 && c < 4) return neg_l[(q + ch) % 4];
                return 0;
            end
            4: return -(r + c);
            default: return 2000;
        endcase
    endfunction

    // Hand-derived pooled result for output (i,j).
    function automatic int expv(input int mode, input int ch, input int i, input int j);
        case (mode)
            1: return 2 * i + 2 * j + 2;
            2: return (ch == 1) ? 7 : (RELU ? 0 : -5);
            3: begin
                if (i == 0 && j == 0) return 2047;
                if (i == 0 && j == 1) return RELU ? 0 : -1;
                return 0;
            end
            4: return RELU ? 0 : -(2 * i + 2 * j);
            default: return 2000;
        endcase
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.valid_in = 1'b0;
        end
    endtask

    task automatic run_frame(input int mode, input bit gaps, input int nbeats);
        exp_t e;
        for (int b = 0; b < nbeats; b++) begin
            int r;
            int c;
            r = b / (2 * HW);
            c = b % (2 * HW);
            if (gaps) idle($urandom_range(0, 2));
            @(negedge clk);
            bus.valid_in  = 1'b1;
            bus.conv_in_1 = CB'(pix(mode, 0, r, c));
            bus.conv_in_2 = CB'(pix(mode, 1, r, c));
            bus.conv_in_3 = CB'(pix(mode, 2, r, c));
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                e.v1  = expv(mode, 0, r / 2, c / 2);
                e.v2  = expv(mode, 1, r / 2, c / 2);
                e.v3  = expv(mode, 2, r / 2, c / 2);
                e.cyc = cyc + 1;
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, int'(bus.valid_out_pool), 0);
        check({tag, "_ch1"}, int'(bus.max_value_1), 0);
        check({tag, "_ch2"}, int'(bus.max_value_2), 0);
        check({tag, "_ch3"}, int'(bus.max_value_3), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: every strobe must match the oldest expected entry, value and timing.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && bus.valid_out_pool) begin
            n_strobe++;
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                e = sb.pop_front();
                check("ch1", int'(bus.max_value_1), e.v1);
                check("ch2", int'(bus.max_value_2), e.v2);
                check("ch3", int'(bus.max_value_3), e.v3);
                check("strobe_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int s0;
        bus.valid_in  = 1'b0;
        bus.conv_in_1 = '0;
        bus.conv_in_2 = '0;
        bus.conv_in_3 = '0;

        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        idle(2);
        check_reset_outputs("post_release");

        // Test 1: contiguous frame, ramp data.
        s0 = n_strobe;
        run_frame(1, 1'b0, 576);
        idle(3);
        check("t1_strobes", n_strobe - s0, 144);

        // Test 2: constant negatives, positive ch2.
        s0 = n_strobe;
        run_frame(2, 1'b0, 576);
        idle(3);
        check("t2_strobes", n_strobe - s0, 144);

        // Test 3: signed extremes in the first two blocks.
        s0 = n_strobe;
        run_frame(3, 1'b0, 576);
        idle(3);
        check("t3_strobes", n_strobe - s0, 144);

        // Test 4: random idle gaps.
        s0 = n_strobe;
        run_frame(1, 1'b1, 576);
        idle(3);
        check("t4_strobes", n_strobe - s0, 144);

        // Test 5: reset mid-frame after 300 beats of stale data.
        s0 = n_strobe;
        run_frame(5, 1'b0, 300);
        idle(2);
        check("t5_partial_strobes", n_strobe - s0, 72);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("t5_rst");
        end
        rst_n = 1'b1;
        idle(2);
        s0 = n_strobe;
        run_frame(1, 1'b0, 576);
        idle(3);
        check("t5_strobes", n_strobe - s0, 144);

        // Test 6: back-to-back frames, second negated.
        s0 = n_strobe;
        run_frame(1, 1'b0, 576);
        run_frame(4, 1'b0, 576);
        idle(3);
        check("t6_strobes", n_strobe - s0, 288);

        idle(4);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
